// File: rtl/change_dispenser.sv
// change_dispenser: pays out change as dime/nickel eject requests over a req/ack handshake,
// reporting the remaining amount in binary and as two BCD digits.
module change_dispenser #(
    parameter int AMT_W       = 6,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             eject_ack,
    input  logic             clear,
    output logic             dime_out,
    output logic             nickel_out,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic             odd_err,
    output logic [AMT_W-1:0] remaining,
    output logic [7:0]       bcd_remaining
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ARM, REQ, REL, FAULT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AMT_W-1:0] rem_q, rem_d, trunc;
    logic [7:0]       bcd_q, bcd_d;
    logic             dime_q, dime_d, nickel_q, nickel_d, done_q, done_d, odd_q, odd_d;
    logic             timeout, pick_dime;

    assign trunc     = amount - amount % AMT_W'(5);
    assign timeout   = cnt_q == CW'(ACK_TIMEOUT - 1);
    assign pick_dime = rem_q >= AMT_W'(10);

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        dime_d   = dime_q;
        nickel_d = nickel_q;
        done_d   = 1'b0;
        odd_d    = odd_q;
        case (state_q)
            IDLE: if (start) begin
                rem_d   = trunc;
                odd_d   = amount % AMT_W'(5) != '0;
                done_d  = trunc == '0;
                state_d = trunc == '0 ? IDLE : ARM;
            end
            ARM: if (!eject_ack) begin
                dime_d   = pick_dime;
                nickel_d = !pick_dime;
                state_d  = REQ;
            end else if (timeout) state_d = FAULT;
            REQ: if (eject_ack) begin
                dime_d   = 1'b0;
                nickel_d = 1'b0;
                rem_d    = rem_q - (dime_q ? AMT_W'(10) : AMT_W'(5));
                state_d  = REL;
            end else if (timeout) begin
                dime_d   = 1'b0;
                nickel_d = 1'b0;
                state_d  = FAULT;
            end
            REL: if (!eject_ack) begin
                done_d   = rem_q == '0;
                dime_d   = rem_q != '0 && pick_dime;
                nickel_d = rem_q != '0 && !pick_dime;
                state_d  = rem_q == '0 ? IDLE : REQ;
            end else if (timeout) state_d = FAULT;
            FAULT: if (clear) begin
                rem_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // The timeout window restarts on every state change, including REL->REQ.
        cnt_d = (state_d != state_q || state_q == IDLE || state_q == FAULT) ? '0 : cnt_q + CW'(1);
        bcd_d = {4'(rem_d / AMT_W'(10)), 4'(rem_d % AMT_W'(10))};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            bcd_q    <= '0;
            dime_q   <= 1'b0;
            nickel_q <= 1'b0;
            done_q   <= 1'b0;
            odd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            bcd_q    <= bcd_d;
            dime_q   <= dime_d;
            nickel_q <= nickel_d;
            done_q   <= done_d;
            odd_q    <= odd_d;
        end
    end

    assign dime_out      = dime_q;
    assign nickel_out    = nickel_q;
    assign busy          = state_q != IDLE;
    assign fault         = state_q == FAULT;
    assign done          = done_q;
    assign odd_err       = odd_q;
    assign remaining     = rem_q;
    assign bcd_remaining = bcd_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table vectors, corner-case sequences and randomized payouts checked
// against an arithmetic model of greedy change-making.
module tb_change_dispenser;
    localparam int AW = 6;
    localparam int TO = 8;

    logic          clk = 0, rst = 0, start = 0, eject_ack = 0, clear = 0;
    logic [AW-1:0] amount = '0;
    logic          dime_out, nickel_out, busy, done, fault, odd_err;
    logic [AW-1:0] remaining;
    logic [7:0]    bcd_remaining;
    int            n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    change_dispenser #(.AMT_W(AW), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .amount(amount), .eject_ack(eject_ack),
        .clear(clear), .dime_out(dime_out), .nickel_out(nickel_out), .busy(busy),
        .done(done), .fault(fault), .odd_err(odd_err), .remaining(remaining),
        .bcd_remaining(bcd_remaining)
    );

    typedef struct {
        int amt;
        int rem;
        int bcd;
        int odd;
        int nd;
        int nn;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int to_bcd(input int v);
        return (v / 10) * 16 + v % 10;
    endfunction

    task automatic run_txn(input int amt, input int e_rem, input int e_bcd, input int e_odd,
                           input int e_d, input int e_n, input bit rnd);
        int mrem, nd, nn, dly, rdly;
        bit req_seen, got_done;
        nd = 0; nn = 0; dly = 0; rdly = 0; req_seen = 0; got_done = 0;
        amount = AW'(amt);
        start = 1;
        tick;
        start = 0;
        chk("latched_rem", remaining, e_rem);
        chk("latched_bcd", bcd_remaining, e_bcd);
        chk("odd_err", odd_err, e_odd);
        mrem = e_rem;
        for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
            if (done) begin
                got_done = 1;
                chk("done_rem", remaining, 0);
                chk("done_bcd", bcd_remaining, 0);
                chk("done_busy", busy, 0);
            end else begin
                if ((dime_out || nickel_out) && !req_seen) begin
                    req_seen = 1;
                    dly = rnd ? int'($urandom_range(0, 3)) : 2;
                    chk("one_hot", dime_out & nickel_out, 0);
                    chk("coin_is_dime", dime_out, mrem >= 10);
                    chk("pre_rem", remaining, mrem);
                    if (dime_out) begin nd++; mrem -= 10; end
                    else begin nn++; mrem -= 5; end
                end
                if (req_seen && (dime_out || nickel_out)) begin
                    if (dly == 0) eject_ack = 1;
                    else dly--;
                end else if (req_seen) begin
                    chk("post_rem", remaining, mrem);
                    chk("post_bcd", bcd_remaining, to_bcd(mrem));
                    req_seen = 0;
                    rdly = rnd ? int'($urandom_range(0, 2)) : 0;
                end
                if (eject_ack && !req_seen) begin
                    if (rdly == 0) eject_ack = 0;
                    else rdly--;
                end
                tick;
            end
        end
        chk("done_seen", got_done, 1);
        chk("dimes", nd, e_d);
        chk("nickels", nn, e_n);
        eject_ack = 0;
        tick;
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        vec_t tbl[10];
        int hi, dn;
        tbl = '{
            '{25, 25, 'h25, 0, 2, 1},
            '{0,  0,  'h00, 0, 0, 0},
            '{17, 15, 'h15, 1, 1, 1},
            '{10, 10, 'h10, 0, 1, 0},
            '{63, 60, 'h60, 1, 6, 0},
            '{5,  5,  'h05, 0, 0, 1},
            '{4,  0,  'h00, 1, 0, 0},
            '{49, 45, 'h45, 1, 4, 1},
            '{55, 55, 'h55, 0, 5, 1},
            '{39, 35, 'h35, 1, 3, 1}
        };
        #12;
        chk("rst_dime", dime_out, 0);
        chk("rst_nickel", nickel_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_odd", odd_err, 0);
        chk("rst_rem", remaining, 0);
        chk("rst_bcd", bcd_remaining, 0);
        @(posedge clk); #1;
        rst = 1;
        tick;

        for (int i = 0; i < 10; i++)
            run_txn(tbl[i].amt, tbl[i].rem, tbl[i].bcd, tbl[i].odd, tbl[i].nd, tbl[i].nn, 0);

        // ack stuck low: fault after TO cycles of request, then clear beats start
        amount = 23; start = 1; tick; start = 0;
        chk("to_busy", busy, 1);
        tick;
        hi = 0;
        for (int i = 0; i < 20 && !fault; i++) begin
            if (dime_out) hi++;
            tick;
        end
        chk("to_req_cycles", hi, TO);
        chk("to_fault", fault, 1);
        chk("to_dime_drop", dime_out, 0);
        chk("to_rem_held", remaining, 20);
        chk("to_bcd_held", bcd_remaining, 'h20);
        tick;
        chk("fault_stays", fault, 1);
        clear = 1; start = 1; amount = 25; tick; clear = 0; start = 0;
        chk("clr_fault", fault, 0);
        chk("clr_rem", remaining, 0);
        chk("clr_busy", busy, 0);
        chk("clr_odd_kept", odd_err, 1);
        tick;
        chk("clr_start_dropped", busy, 0);

        // ack high at start: wait in ARM, ignore start while busy
        eject_ack = 1; amount = 5; start = 1; tick; start = 0;
        chk("arm_busy", busy, 1);
        chk("arm_no_req", dime_out | nickel_out, 0);
        tick;
        amount = 30; start = 1; tick; start = 0;
        chk("arm_start_ign", remaining, 5);
        chk("arm_still_no_req", dime_out | nickel_out, 0);
        eject_ack = 0; tick;
        chk("arm_nickel", nickel_out, 1);
        chk("arm_no_dime", dime_out, 0);
        eject_ack = 1; tick;
        chk("arm_nickel_drop", nickel_out, 0);
        chk("arm_rem0", remaining, 0);
        eject_ack = 0; tick;
        chk("arm_done", done, 1);
        tick;
        chk("arm_idle", busy, 0);

        // async reset mid-handshake
        amount = 30; start = 1; tick; start = 0; tick;
        chk("mid_dime", dime_out, 1);
        #2 rst = 0;
        #1;
        chk("mid_dime_rst", dime_out, 0);
        chk("mid_busy_rst", busy, 0);
        chk("mid_rem_rst", remaining, 0);
        chk("mid_bcd_rst", bcd_remaining, 0);
        @(posedge clk); #1;
        rst = 1;
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (done) dn++;
        end
        chk("mid_no_done", dn, 0);
        chk("mid_idle", busy, 0);

        for (int i = 0; i < 40; i++) begin
            int a, r;
            a = int'($urandom_range(0, 63));
            r = a - a % 5;
            run_txn(a, r, to_bcd(r), int'(a % 5 != 0), r / 10, int'(r % 10 != 0), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Pays out change as dime and nickel eject requests to the coin-return mechanism. It is the payout end of the coin interface, where the vending state machine is the coin-accept end.
- Takes a change amount in cents from the vending controller and issues one coin request at a time, each with a req/ack handshake.
- Exposes the remaining amount in binary and as two BCD digits so the 7-segment driver can show it.

Parameters:
AMT_W, 6, width of amount/remaining in cents (max 63)
ACK_TIMEOUT, 1000, clock cycles allowed per handshake phase before FAULT

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-low (asserted at 0)
start  input  1  1-cycle request to pay out amount; sampled only in IDLE
amount  input  AMT_W  change in cents, latched on the start cycle
eject_ack  input  1  mechanism acknowledge (high = coin ejected)
clear  input  1  leaves FAULT; ignored in other states
dime_out  output  1  dime eject request (registered)
nickel_out  output  1  nickel eject request (registered)
busy  output  1  high in any state other than IDLE
done  output  1  1-cycle pulse when payout completes
fault  output  1  high while in FAULT
odd_err  output  1  sticky flag: latched amount was not a multiple of 5
remaining  output  AMT_W  cents still to be paid
bcd_remaining  output  8  {tens, ones} BCD of remaining; ones in [3:0]

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0; remaining=0; bcd_remaining=8'h00; timeout counter 0.
- States: IDLE, ARM, REQ, REL, FAULT. All outputs are registered.
- IDLE:
  - On start=1, latch remaining <= amount - (amount mod 5) and set odd_err <= (amount mod 5 != 0).
  - If the truncated value is 0, pulse done next cycle and stay in IDLE. Otherwise go to ARM.
  - start is ignored in every state other than IDLE.
- ARM:
  - Waits for eject_ack=0; handles ack still high from a previous cycle.
  - On ack=0: if remaining>=10, assert dime_out; else assert nickel_out. Then go to REQ.
  - Exactly one of dime_out/nickel_out is ever high.
- REQ:
  - Request held high until eject_ack=1 is sampled.
  - On that edge: request drops to 0, remaining decrements by 10 (dime) or 5 (nickel), go to REL.
- REL:
  - Waits for eject_ack=0.
  - If remaining==0: pulse done for 1 cycle and go to IDLE (busy falls on the same edge).
  - Otherwise select the next coin as in ARM and go directly to REQ with the request asserted.
- Timeout:
  - Counter resets on every state entry and counts cycles in ARM, REQ and REL.
  - When it reaches ACK_TIMEOUT-1: go to FAULT, drop both requests, fault=1.
  - remaining is frozen in FAULT.
- FAULT: on clear=1, go to IDLE with remaining=0, fault=0. odd_err keeps its value until the next accepted start.
- Latency, start to first request: 2 cycles if ack=0 (IDLE->ARM, ARM->REQ with request registered).
- Coin selection: greedy, so N cents pays floor(N/10) dimes then at most one nickel.
- bcd_remaining updates on the same edge as remaining. tens = remaining/10, ones = remaining mod 10. Valid for all values up to 63.
- Simultaneous events:
  - start and clear in the same cycle in FAULT: clear wins, start is dropped.
  - eject_ack=1 on the same cycle a request is first registered: counted as an ack on the next edge only, because ack is sampled against the registered request.
- Reset mid-handshake: requests drop asynchronously; no done pulse.

Test Plan:
- Reset then amount=25, start, ack responds 2 cycles after each request -> sequence dime, dime, nickel. remaining goes 25->15->5->0; bcd_remaining 8'h25->8'h15->8'h05->8'h00; one done pulse; odd_err=0.
- amount=0, start -> done pulses the next cycle; no requests; busy stays 0.
- amount=17, start -> odd_err=1, remaining=15, one dime then one nickel, done. Next start with amount=10 clears odd_err.
- eject_ack stuck low with ACK_TIMEOUT=8 -> dime_out high for 8 cycles, then fault=1, dime_out=0, remaining=20 held. clear -> IDLE, remaining=0, fault=0.
- eject_ack held high at start with amount=5 -> stays in ARM with no request until ack=0, then nickel_out; start pulses while busy are ignored.
- rst driven low while dime_out=1 with amount=30 -> all outputs 0 immediately; after release, state is IDLE and no done pulse appears.
